instr_encoder: RTL and testbench

- Producer side of the main control decoder: packs instruction fields into 32-bit RV32I words for exactly the five opcode classes the decoder recognises (R, load, I-ALU, store, branch).
- Writes the encoded words sequentially into instruction memory for bench/boot program loading.
- Structure: input valid/ready handshake, DEPTH-entry FIFO, registered memory-write stage with backpressure and an auto-incrementing word address.

---
 rtl/instr_encoder_if.sv | 35 +++
 rtl/instr_encoder.sv | 121 ++++++++++++
 tb/tb_instr_encoder.sv | 416 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_encoder_if.sv
// Handshake bundle for instr_encoder: field input side and imem write side.
// slave = encoder view, master = producer/memory view.
interface instr_encoder_if #(
   parameter int ADDR_W = 8
);
   logic              in_valid;
   logic              in_ready;
   logic [2:0]        in_fmt;
   logic [2:0]        in_funct3;
   logic [6:0]        in_funct7;
   logic [4:0]        in_rd;
   logic [4:0]        in_rs1;
   logic [4:0]        in_rs2;
   logic [12:0]       in_imm;
   logic              imem_we;
   logic              imem_ready;
   logic [ADDR_W-1:0] imem_addr;
   logic [31:0]       imem_wdata;

   modport slave (
      input  in_valid, in_fmt, in_funct3, in_funct7,
      input  in_rd, in_rs1, in_rs2, in_imm,
      output in_ready,
      output imem_we, imem_addr, imem_wdata,
      input  imem_ready
   );

   modport master (
      output in_valid, in_fmt, in_funct3, in_funct7,
      output in_rd, in_rs1, in_rs2, in_imm,
      input  in_ready,
      input  imem_we, imem_addr, imem_wdata,
      output imem_ready
   );
endinterface

// File: rtl/instr_encoder.sv
// RV32I field packer: handshake in, DEPTH FIFO, registered imem writer.
// Ports: clk, rst_n, clear, bus (slave), busy, err.
module instr_encoder #(
   parameter int DEPTH     = 4,
   parameter int ADDR_W    = 8,
   parameter int BASE_ADDR = 0
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            clear,
   instr_encoder_if.slave  bus,
   output logic            busy,
   output logic            err
);
   localparam int PW = $clog2(DEPTH);

   logic [31:0]       mem_q [DEPTH];
   logic [PW:0]       wp_q, wp_d, rp_q, rp_d;
   logic              we_q, we_d;
   logic [31:0]       data_q, data_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              err_q, err_d;

   logic        full, empty, accept, push, load;
   logic        legal;
   logic [31:0] enc;

   assign empty = (wp_q == rp_q);
   assign full  = (wp_q[PW] != rp_q[PW]) &&
                  (wp_q[PW-1:0] == rp_q[PW-1:0]);

   assign bus.in_ready = rst_n && !full && !clear;
   assign accept = bus.in_valid && bus.in_ready;
   assign push   = accept && legal;
   // Output register refills when idle or its word is leaving.
   assign load   = !we_q || bus.imem_ready;

   always_comb begin
      enc   = '0;
      legal = 1'b1;
      unique case (bus.in_fmt)
         3'd0: enc = {bus.in_funct7, bus.in_rs2, bus.in_rs1,
                      bus.in_funct3, bus.in_rd, 7'b0110011};
         3'd1: enc = {bus.in_imm[11:0], bus.in_rs1,
                      bus.in_funct3, bus.in_rd, 7'b0000011};
         3'd2: begin
            if (bus.in_funct3 == 3'b001 || bus.in_funct3 == 3'b101)
               enc = {bus.in_funct7, bus.in_imm[4:0], bus.in_rs1,
                      bus.in_funct3, bus.in_rd, 7'b0010011};
            else
               enc = {bus.in_imm[11:0], bus.in_rs1,
                      bus.in_funct3, bus.in_rd, 7'b0010011};
         end
         3'd3: enc = {bus.in_imm[11:5], bus.in_rs2, bus.in_rs1,
                      bus.in_funct3, bus.in_imm[4:0], 7'b0100011};
         3'd4: begin
            legal = !bus.in_imm[0];
            enc   = {bus.in_imm[12], bus.in_imm[10:5], bus.in_rs2,
                     bus.in_rs1, bus.in_funct3, bus.in_imm[4:1],
                     bus.in_imm[11], 7'b1100011};
         end
         default: legal = 1'b0;
      endcase
   end

   always_comb begin
      wp_d   = wp_q;
      rp_d   = rp_q;
      we_d   = we_q;
      data_d = data_q;
      addr_d = addr_q;
      err_d  = err_q;
      if (clear) begin
         wp_d   = '0;
         rp_d   = '0;
         we_d   = 1'b0;
         data_d = '0;
         addr_d = ADDR_W'(BASE_ADDR);
         err_d  = 1'b0;
      end else begin
         if (accept && !legal) err_d = 1'b1;
         if (push) wp_d = wp_q + (PW+1)'(1);
         if (we_q && bus.imem_ready) addr_d = addr_q + ADDR_W'(1);
         if (load) begin
            we_d = !empty;
            if (!empty) begin
               data_d = mem_q[rp_q[PW-1:0]];
               rp_d   = rp_q + (PW+1)'(1);
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push && !clear) mem_q[wp_q[PW-1:0]] <= enc;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wp_q   <= '0;
         rp_q   <= '0;
         we_q   <= 1'b0;
         data_q <= '0;
         addr_q <= ADDR_W'(BASE_ADDR);
         err_q  <= 1'b0;
      end else begin
         wp_q   <= wp_d;
         rp_q   <= rp_d;
         we_q   <= we_d;
         data_q <= data_d;
         addr_q <= addr_d;
         err_q  <= err_d;
      end
   end

   assign bus.imem_we    = we_q;
   assign bus.imem_addr  = addr_q;
   assign bus.imem_wdata = data_q;
   assign busy = !empty || we_q;
   assign err  = err_q;
endmodule

// File: tb/tb_instr_encoder.sv
// Randomized self-checking bench for instr_encoder.
// Reference model encodes from field rules; writes logged at negedge.
module tb_instr_encoder;
   logic clk = 0;
   logic rst_n = 0;
   logic clear = 0;
   logic busy, err;

   instr_encoder_if #(.ADDR_W(8)) bus ();

   instr_encoder #(.DEPTH(4), .ADDR_W(8), .BASE_ADDR(0)) dut (
      .clk(clk), .rst_n(rst_n), .clear(clear),
      .bus(bus), .busy(busy), .err(err)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_mis = 0;
   int cyc = 0;
   int mdl_addr = 0;
   bit exp_err = 0;
   logic [31:0] exp_q[$];
   logic [7:0]  log_a[$];
   logic [31:0] log_d[$];
   int          log_c[$];

   always @(posedge clk) cyc++;

   always @(negedge clk)
      if (rst_n && !clear && bus.imem_we && bus.imem_ready) begin
         log_a.push_back(bus.imem_addr);
         log_d.push_back(bus.imem_wdata);
         log_c.push_back(cyc);
      end

   function automatic bit is_legal(int fmt, int imm);
      if (fmt > 4) return 0;
      if (fmt == 4 && (imm % 2) == 1) return 0;
      return 1;
   endfunction

   function automatic logic [31:0] ref_enc(
      int fmt, int f3, int f7, int rd, int rs1, int rs2, int imm);
      logic [31:0] w, lo5, hi7, i12, regs;
      lo5  = 32'(imm % 32);
      hi7  = 32'((imm / 32) % 128);
      i12  = 32'(imm % 4096);
      regs = (32'(rs1) << 15) | (32'(f3) << 12);
      case (fmt)
         0: w = (32'(f7) << 25) | (32'(rs2) << 20) | regs
                | (32'(rd) << 7) | 32'h33;
         1: w = (i12 << 20) | regs | (32'(rd) << 7) | 32'h03;
         2: if (f3 == 1 || f3 == 5)
               w = (32'(f7) << 25) | (lo5 << 20) | regs
                   | (32'(rd) << 7) | 32'h13;
            else
               w = (i12 << 20) | regs | (32'(rd) << 7) | 32'h13;
         3: w = (hi7 << 25) | (32'(rs2) << 20) | regs
                | (lo5 << 7) | 32'h23;
         default:
            w = (32'((imm / 4096) % 2) << 31)
                | (32'((imm / 32) % 64) << 25)
                | (32'(rs2) << 20) | regs
                | (32'((imm / 2) % 16) << 8)
                | (32'((imm / 2048) % 2) << 7) | 32'h63;
      endcase
      return w;
   endfunction

   task automatic send(input int fmt, f3, f7, rd, rs1, rs2, imm);
      bus.in_fmt    = 3'(fmt);
      bus.in_funct3 = 3'(f3);
      bus.in_funct7 = 7'(f7);
      bus.in_rd     = 5'(rd);
      bus.in_rs1    = 5'(rs1);
      bus.in_rs2    = 5'(rs2);
      bus.in_imm    = 13'(imm);
      bus.in_valid  = 1;
      for (int n = 0; ; n++) begin
         @(negedge clk);
         if (bus.in_ready) break;
         if (n > 300) begin
            n_cmp++; n_mis++;
            $display("FAIL send_timeout in_ready=%0b want 1", bus.in_ready);
            bus.in_valid = 0;
            return;
         end
      end
      @(posedge clk); #1;
      bus.in_valid = 0;
      if (is_legal(fmt, imm)) exp_q.push_back(ref_enc(fmt, f3, f7, rd, rs1, rs2, imm));
      else exp_err = 1;
   endtask

   task automatic drain();
      for (int n = 0; ; n++) begin
         @(negedge clk);
         if (!busy) break;
         if (n > 2000) begin
            n_cmp++; n_mis++;
            $display("FAIL drain_timeout busy=%0b want 0", busy);
            break;
         end
      end
      @(posedge clk); #1;
   endtask

   task automatic rand_send(input bit allow_bad);
      int fmt, imm;
      fmt = allow_bad ? $urandom_range(0, 6) : $urandom_range(0, 4);
      imm = $urandom_range(0, 8191);
      if (!allow_bad && fmt == 4) imm = imm & ~1;
      send(fmt, $urandom_range(0, 7), $urandom_range(0, 127),
           $urandom_range(0, 31), $urandom_range(0, 31),
           $urandom_range(0, 31), imm);
   endtask

   task automatic test_reset();
      #2;
      n_cmp++;
      if (bus.in_ready !== 0) begin
         n_mis++; $display("FAIL rst_in_ready got %0b want 0", bus.in_ready);
      end
      @(posedge clk); #1 rst_n = 1;
      @(negedge clk);
      n_cmp++;
      if (bus.in_ready !== 1 || bus.imem_we !== 0 || bus.imem_wdata !== 0 ||
          bus.imem_addr !== 0 || busy !== 0 || err !== 0) begin
         n_mis++;
         $display("FAIL rst_state rdy=%0b we=%0b d=%h a=%h busy=%0b err=%0b want 1 0 0 0 0 0",
                  bus.in_ready, bus.imem_we, bus.imem_wdata, bus.imem_addr, busy, err);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_r_basic();
      send(0, 0, 0, 3, 1, 2, 0);
      drain();
      n_cmp++;
      if (log_d.size() !== 1 || log_a[0] !== 8'h00 || log_d[0] !== 32'h002081B3) begin
         n_mis++;
         $display("FAIL r_basic n=%0d a=%h d=%h want 1 00 002081b3",
                  log_d.size(), log_a[0], log_d[0]);
      end
      n_cmp++;
      if (log_d[0] !== exp_q[0]) begin
         n_mis++; $display("FAIL r_model got %h want %h", log_d[0], exp_q[0]);
      end
      mdl_addr = 1;
      exp_q.delete(); log_a.delete(); log_d.delete(); log_c.delete();
   endtask

   task automatic test_back_to_back();
      logic [31:0] want [4];
      want = '{32'h00812283, 32'hFFF00093, 32'h00612623, 32'hFE208CE3};
      send(1, 2, 0, 5, 2, 0, 8);
      send(2, 0, 0, 1, 0, 0, 12'hFFF);
      send(3, 2, 0, 0, 2, 6, 12);
      send(4, 0, 0, 0, 1, 2, 13'h1FF8);
      drain();
      n_cmp++;
      if (log_d.size() !== 4) begin
         n_mis++; $display("FAIL b2b_count got %0d want 4", log_d.size());
      end
      for (int i = 0; i < 4 && i < log_d.size(); i++) begin
         n_cmp++;
         if (log_d[i] !== want[i] || log_d[i] !== exp_q[i] ||
             log_a[i] !== 8'(mdl_addr + i)) begin
            n_mis++;
            $display("FAIL b2b_%0d a=%h d=%h want %h %h", i, log_a[i],
                     log_d[i], 8'(mdl_addr + i), want[i]);
         end
         if (i > 0) begin
            n_cmp++;
            if (log_c[i] - log_c[i-1] !== 1) begin
               n_mis++;
               $display("FAIL b2b_gap_%0d got %0d want 1", i, log_c[i] - log_c[i-1]);
            end
         end
      end
      mdl_addr += 4;
      exp_q.delete(); log_a.delete(); log_d.delete(); log_c.delete();
   endtask

   task automatic test_shifts();
      send(2, 1, 0, 1, 1, 0, 3);
      send(2, 5, 7'h20, 1, 1, 0, 3);
      drain();
      n_cmp++;
      if (log_d.size() !== 2 || log_d[0] !== 32'h00309093 ||
          log_d[1] !== 32'h4030D093) begin
         n_mis++;
         $display("FAIL shifts n=%0d d0=%h d1=%h want 2 00309093 4030d093",
                  log_d.size(), log_d[0], log_d[1]);
      end
      mdl_addr += 2;
      exp_q.delete(); log_a.delete(); log_d.delete(); log_c.delete();
   endtask

   task automatic test_stall();
      logic [7:0] a0;
      logic [31:0] d0;
      bus.imem_ready = 0;
      for (int i = 0; i < 5; i++) rand_send(0);
      @(negedge clk);
      n_cmp++;
      if (bus.in_ready !== 0 || bus.imem_we !== 1) begin
         n_mis++;
         $display("FAIL stall_full rdy=%0b we=%0b want 0 1", bus.in_ready, bus.imem_we);
      end
      a0 = bus.imem_addr; d0 = bus.imem_wdata;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         n_cmp++;
         if (bus.imem_addr !== a0 || bus.imem_wdata !== d0 || bus.in_ready !== 0) begin
            n_mis++;
            $display("FAIL stall_hold a=%h d=%h rdy=%0b want %h %h 0",
                     bus.imem_addr, bus.imem_wdata, bus.in_ready, a0, d0);
         end
      end
      @(posedge clk); #1;
      bus.imem_ready = 1;
      rand_send(0);
      drain();
      n_cmp++;
      if (log_d.size() !== 6) begin
         n_mis++; $display("FAIL stall_count got %0d want 6", log_d.size());
      end
      for (int i = 0; i < exp_q.size() && i < log_d.size(); i++) begin
         n_cmp++;
         if (log_d[i] !== exp_q[i] || log_a[i] !== 8'(mdl_addr)) begin
            n_mis++;
            $display("FAIL stall_wr_%0d a=%h d=%h want %h %h", i, log_a[i],
                     log_d[i], 8'(mdl_addr), exp_q[i]);
         end
         mdl_addr++;
      end
      exp_q.delete(); log_a.delete(); log_d.delete(); log_c.delete();
   endtask

   task automatic test_illegal_clear();
      send(6, 0, 0, 1, 1, 1, 0);
      send(4, 0, 0, 0, 1, 2, 5);
      repeat (3) @(posedge clk); #1;
      n_cmp++;
      if (err !== exp_err || err !== 1 || log_d.size() !== 0 || busy !== 0) begin
         n_mis++;
         $display("FAIL illegal err=%0b writes=%0d busy=%0b want 1 0 0",
                  err, log_d.size(), busy);
      end
      send(1, 2, 0, 7, 3, 0, 100);
      drain();
      n_cmp++;
      if (log_d.size() !== 1 || log_a[0] !== 8'(mdl_addr) || log_d[0] !== exp_q[0]) begin
         n_mis++;
         $display("FAIL illegal_next n=%0d a=%h d=%h want 1 %h %h",
                  log_d.size(), log_a[0], log_d[0], 8'(mdl_addr), exp_q[0]);
      end
      mdl_addr++;
      exp_q.delete(); log_a.delete(); log_d.delete(); log_c.delete();
      bus.imem_ready = 0;
      rand_send(0);
      rand_send(0);
      repeat (2) @(posedge clk); #1;
      clear = 1;
      bus.imem_ready = 1;
      bus.in_fmt = 0;
      bus.in_valid = 1;
      @(negedge clk);
      n_cmp++;
      if (bus.in_ready !== 0) begin
         n_mis++; $display("FAIL clear_ready got %0b want 0", bus.in_ready);
      end
      @(posedge clk); #1;
      clear = 0;
      bus.in_valid = 0;
      exp_q.delete(); exp_err = 0; mdl_addr = 0;
      @(negedge clk);
      n_cmp++;
      if (bus.imem_we !== 0 || busy !== 0 || err !== 0 || bus.imem_addr !== 0 ||
          log_d.size() !== 0) begin
         n_mis++;
         $display("FAIL clear_state we=%0b busy=%0b err=%0b a=%h writes=%0d want 0 0 0 00 0",
                  bus.imem_we, busy, err, bus.imem_addr, log_d.size());
      end
      @(posedge clk); #1;
   endtask

   task automatic test_random();
      bit stop = 0;
      fork
         begin
            for (int i = 0; i < 40; i++) rand_send(1);
            stop = 1;
         end
         begin
            while (!stop) begin
               @(posedge clk); #1;
               bus.imem_ready = 1'($urandom_range(0, 1));
            end
         end
      join
      bus.imem_ready = 1;
      drain();
      n_cmp++;
      if (err !== exp_err) begin
         n_mis++; $display("FAIL rand_err got %0b want %0b", err, exp_err);
      end
      n_cmp++;
      if (log_d.size() !== exp_q.size()) begin
         n_mis++;
         $display("FAIL rand_count got %0d want %0d", log_d.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < log_d.size(); i++) begin
         n_cmp++;
         if (log_d[i] !== exp_q[i] || log_a[i] !== 8'(mdl_addr)) begin
            n_mis++;
            $display("FAIL rand_wr_%0d a=%h d=%h want %h %h", i, log_a[i],
                     log_d[i], 8'(mdl_addr), exp_q[i]);
         end
         mdl_addr = (mdl_addr + 1) % 256;
      end
      exp_q.delete(); log_a.delete(); log_d.delete(); log_c.delete();
   endtask

   task automatic test_wrap();
      clear = 1;
      @(posedge clk); #1;
      clear = 0;
      mdl_addr = 0; exp_err = 0;
      for (int i = 0; i < 255; i++) rand_send(0);
      drain();
      n_cmp++;
      if (bus.imem_addr !== 8'hFF) begin
         n_mis++; $display("FAIL wrap_pre got %h want ff", bus.imem_addr);
      end
      rand_send(0);
      rand_send(0);
      drain();
      n_cmp++;
      if (log_d.size() !== 257 || log_a[255] !== 8'hFF || log_a[256] !== 8'h00) begin
         n_mis++;
         $display("FAIL wrap n=%0d a255=%h a256=%h want 257 ff 00",
                  log_d.size(), log_a[255], log_a[256]);
      end
      for (int i = 0; i < exp_q.size() && i < log_d.size(); i++) begin
         if (log_d[i] !== exp_q[i] || log_a[i] !== 8'(mdl_addr)) begin
            n_cmp++; n_mis++;
            $display("FAIL wrap_wr_%0d a=%h d=%h want %h %h", i, log_a[i],
                     log_d[i], 8'(mdl_addr), exp_q[i]);
         end
         mdl_addr = (mdl_addr + 1) % 256;
      end
      n_cmp++;
      exp_q.delete(); log_a.delete(); log_d.delete(); log_c.delete();
   endtask

   task automatic test_reset_midstall();
      bus.imem_ready = 0;
      rand_send(0);
      for (int n = 0; ; n++) begin
         @(negedge clk);
         if (bus.imem_we) break;
         if (n > 20) begin
            n_cmp++; n_mis++;
            $display("FAIL midrst_we_timeout we=%0b want 1", bus.imem_we);
            break;
         end
      end
      #2 rst_n = 0;
      #1;
      n_cmp++;
      if (bus.imem_we !== 0 || busy !== 0 || bus.in_ready !== 0 ||
          bus.imem_addr !== 0 || err !== 0) begin
         n_mis++;
         $display("FAIL midrst we=%0b busy=%0b rdy=%0b a=%h err=%0b want 0 0 0 00 0",
                  bus.imem_we, busy, bus.in_ready, bus.imem_addr, err);
      end
      exp_q.delete(); mdl_addr = 0; exp_err = 0;
      @(posedge clk); #1;
      rst_n = 1;
      bus.imem_ready = 1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_cmp++;
      if (log_d.size() !== 0 || bus.in_ready !== 1 || busy !== 0) begin
         n_mis++;
         $display("FAIL midrst_after writes=%0d rdy=%0b busy=%0b want 0 1 0",
                  log_d.size(), bus.in_ready, busy);
      end
   endtask

   initial begin
      bus.in_valid = 0;
      bus.in_fmt = 0;
      bus.in_funct3 = 0;
      bus.in_funct7 = 0;
      bus.in_rd = 0;
      bus.in_rs1 = 0;
      bus.in_rs2 = 0;
      bus.in_imm = 0;
      bus.imem_ready = 1;
      test_reset();
      test_r_basic();
      test_back_to_back();
      test_shifts();
      test_stall();
      test_illegal_clear();
      test_random();
      test_wrap();
      test_reset_midstall();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end
endmodule
